// File: rtl/pc_fetch_32_if.sv
// Fetch-stage bus: redirect input, decode handshake and instruction-memory request/ack.
// Optional misalignErr exists only when PC_MISALIGN_TRAP_EN is defined.
interface pc_fetch_32_if;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        stall;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic [31:0] instr;
    logic        instrValid;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalignErr;

    modport master (
        input  redirectValid, redirectPc, stall, imemAck, imemData,
        output imemReq, imemAddr, instr, instrValid, pc, pcPlus4, misalignErr
    );
    modport slave (
        output redirectValid, redirectPc, stall, imemAck, imemData,
        input  imemReq, imemAddr, instr, instrValid, pc, pcPlus4, misalignErr
    );
`else
    modport master (
        input  redirectValid, redirectPc, stall, imemAck, imemData,
        output imemReq, imemAddr, instr, instrValid, pc, pcPlus4
    );
    modport slave (
        output redirectValid, redirectPc, stall, imemAck, imemData,
        input  imemReq, imemAddr, instr, instrValid, pc, pcPlus4
    );
`endif
endinterface

// File: rtl/pc_fetch_32.sv
// Program counter and instruction fetch stage; PC_MISALIGN_TRAP_EN enables misaligned-redirect trap.
// Latency: instruction valid 1 cycle after imemAck; best case one instruction per 2 cycles.
// Backpressure: stall holds the delivered instruction; imemReq/imemAddr held until imemAck.
module pc_fetch_32 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_fetch_32_if.master bus
);
    typedef enum logic [1:0] {BOOT, FETCH, DELIVER} state_t;

    state_t      state_q, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] instr_q, instr_n;
    logic [31:0] pending_q, pending_n;
    logic        vld_q, vld_n;
    logic        squash_q, squash_n;
    logic [31:0] pc_inc;
    logic [31:0] redir_tgt;
    logic        redir_ok;

    assign pc_inc = pc_q + 32'(PC_STEP);

`ifdef PC_MISALIGN_TRAP_EN
    logic err_q;

    // Misaligned targets are dropped entirely and reported one cycle later.
    assign redir_ok  = bus.redirectValid && (bus.redirectPc[1:0] == 2'b00);
    assign redir_tgt = bus.redirectPc;

    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= bus.redirectValid && (bus.redirectPc[1:0] != 2'b00);
    end
    assign bus.misalignErr = err_q;
`else
    assign redir_ok  = bus.redirectValid;
    assign redir_tgt = bus.redirectPc & ~32'h3;
`endif

    always_comb begin
        state_n   = state_q;
        pc_n      = pc_q;
        instr_n   = instr_q;
        pending_n = pending_q;
        vld_n     = vld_q;
        squash_n  = squash_q;
        case (state_q)
            BOOT: begin
                if (redir_ok) pc_n = redir_tgt;
                state_n = FETCH;
            end
            FETCH: begin
                if (bus.imemAck) begin
                    // A redirect coincident with ack is newer than any pending one.
                    if (redir_ok) begin
                        pc_n     = redir_tgt;
                        squash_n = 1'b0;
                    end else if (squash_q) begin
                        pc_n     = pending_q;
                        squash_n = 1'b0;
                    end else begin
                        instr_n = bus.imemData;
                        vld_n   = 1'b1;
                        state_n = DELIVER;
                    end
                end else if (redir_ok) begin
                    squash_n  = 1'b1;
                    pending_n = redir_tgt;
                end
            end
            DELIVER: begin
                if (redir_ok) begin
                    pc_n    = redir_tgt;
                    vld_n   = 1'b0;
                    state_n = FETCH;
                end else if (!bus.stall) begin
                    pc_n    = pc_inc;
                    vld_n   = 1'b0;
                    state_n = FETCH;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0;
            pending_q <= 32'h0;
            vld_q     <= 1'b0;
            squash_q  <= 1'b0;
        end else begin
            state_q   <= state_n;
            pc_q      <= pc_n;
            instr_q   <= instr_n;
            pending_q <= pending_n;
            vld_q     <= vld_n;
            squash_q  <= squash_n;
        end
    end

    assign bus.imemReq    = (state_q == FETCH);
    assign bus.imemAddr   = pc_q;
    assign bus.pc         = pc_q;
    assign bus.pcPlus4    = pc_inc;
    assign bus.instr      = instr_q;
    assign bus.instrValid = vld_q;
endmodule

// File: tb/tb_pc_fetch_32.sv
// Directed bench for pc_fetch_32: sequential fetch, stall, redirects, misalign, wrap and reset.
module tb_pc_fetch_32;
    logic clk = 1'b0;
    logic rst_n;
    logic rst_nb;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_fetch_32_if ifa ();
    pc_fetch_32_if ifb ();

    pc_fetch_32 #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.master)
    );
    pc_fetch_32 #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_b (
        .clk(clk), .rst_n(rst_nb), .bus(ifb.master)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rst_nb = 1'b0;
        ifa.redirectValid = 1'b0; ifa.redirectPc = 32'h0; ifa.stall = 1'b0;
        ifa.imemAck = 1'b0; ifa.imemData = 32'h0;
        ifb.redirectValid = 1'b0; ifb.redirectPc = 32'h0; ifb.stall = 1'b0;
        ifb.imemAck = 1'b0; ifb.imemData = 32'h0;
        step(); step();

        // reset state
        chk("rst_pc", ifa.pc, 32'h0);
        chk("rst_instr", ifa.instr, 32'h0);
        chk("rst_vld", 32'(ifa.instrValid), 32'h0);
        chk("rst_req", 32'(ifa.imemReq), 32'h0);
        chk("rst_addr", ifa.imemAddr, 32'h0);
        chk("rst_plus4", ifa.pcPlus4, 32'h4);

        // sequential fetch with zero-wait memory
        rst_n = 1'b1;
        step();
        chk("f0_req", 32'(ifa.imemReq), 32'h1);
        chk("f0_addr", ifa.imemAddr, 32'h0);
        ifa.imemAck = 1'b1; ifa.imemData = 32'hA000_0001;
        step();
        chk("d0_vld", 32'(ifa.instrValid), 32'h1);
        chk("d0_instr", ifa.instr, 32'hA000_0001);
        chk("d0_req", 32'(ifa.imemReq), 32'h0);
        chk("d0_plus4", ifa.pcPlus4, 32'h4);
        ifa.imemAck = 1'b0;
        step();
        chk("f1_addr", ifa.imemAddr, 32'h4);
        chk("f1_vld", 32'(ifa.instrValid), 32'h0);
        ifa.imemAck = 1'b1; ifa.imemData = 32'hA000_0002;
        step();
        chk("d1_instr", ifa.instr, 32'hA000_0002);
        chk("d1_plus4", ifa.pcPlus4, 32'h8);
        ifa.imemAck = 1'b0;

        // stall hold for 3 cycles
        ifa.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_instr", ifa.instr, 32'hA000_0002);
            chk("stall_pc", ifa.pc, 32'h4);
            chk("stall_vld", 32'(ifa.instrValid), 32'h1);
        end
        ifa.stall = 1'b0;
        step();
        chk("post_stall_addr", ifa.imemAddr, 32'h8);

        // redirect while ack withheld
        ifa.redirectValid = 1'b1; ifa.redirectPc = 32'h100;
        step();
        ifa.redirectValid = 1'b0;
        chk("wait_addr_hold", ifa.imemAddr, 32'h8);
        step(); step();
        chk("wait_addr_hold3", ifa.imemAddr, 32'h8);
        chk("wait_vld", 32'(ifa.instrValid), 32'h0);
        ifa.imemAck = 1'b1; ifa.imemData = 32'hDEAD_BEEF;
        step();
        chk("squash_vld", 32'(ifa.instrValid), 32'h0);
        chk("squash_addr", ifa.imemAddr, 32'h100);
        chk("squash_req", 32'(ifa.imemReq), 32'h1);
        ifa.imemData = 32'h1111_1111;
        step();
        chk("tgt_instr", ifa.instr, 32'h1111_1111);
        chk("tgt_pc", ifa.pc, 32'h100);
        ifa.imemAck = 1'b0;

        // redirect beats stall in DELIVER
        ifa.stall = 1'b1; ifa.redirectValid = 1'b1; ifa.redirectPc = 32'h40;
        step();
        ifa.stall = 1'b0; ifa.redirectValid = 1'b0;
        chk("rs_vld", 32'(ifa.instrValid), 32'h0);
        chk("rs_addr", ifa.imemAddr, 32'h40);
        ifa.imemAck = 1'b1; ifa.imemData = 32'h2222_2222;
        step();
        ifa.imemAck = 1'b0;
        chk("rs_instr", ifa.instr, 32'h2222_2222);

        // misaligned redirect in DELIVER while stalled
        ifa.stall = 1'b1; ifa.redirectValid = 1'b1; ifa.redirectPc = 32'h102;
        step();
        ifa.redirectValid = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis_pc", ifa.pc, 32'h40);
        chk("mis_vld", 32'(ifa.instrValid), 32'h1);
        chk("mis_err", 32'(ifa.misalignErr), 32'h1);
        step();
        chk("mis_err_pulse", 32'(ifa.misalignErr), 32'h0);
        ifa.stall = 1'b0;
        step();
        chk("mis_next_addr", ifa.imemAddr, 32'h44);
`else
        chk("mis_pc", ifa.pc, 32'h100);
        chk("mis_vld", 32'(ifa.instrValid), 32'h0);
        ifa.stall = 1'b0;
`endif

        // reset during an outstanding request, then late ack in BOOT
        chk("pre_rst_req", 32'(ifa.imemReq), 32'h1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_pc", ifa.pc, 32'h0);
        chk("mid_rst_req", 32'(ifa.imemReq), 32'h0);
        chk("mid_rst_vld", 32'(ifa.instrValid), 32'h0);
        chk("mid_rst_instr", ifa.instr, 32'h0);
        rst_n = 1'b1; ifa.imemAck = 1'b1; ifa.imemData = 32'h3333_3333;
        step();
        ifa.imemAck = 1'b0;
        chk("late_ack_vld", 32'(ifa.instrValid), 32'h0);
        chk("late_ack_instr", ifa.instr, 32'h0);
        chk("late_ack_addr", ifa.imemAddr, 32'h0);
        chk("late_ack_req", 32'(ifa.imemReq), 32'h1);

        // address wrap from RESET_PC = FFFF_FFFC
        chk("wrap_addr0", ifb.imemAddr, 32'hFFFF_FFFC);
        chk("wrap_plus4", ifb.pcPlus4, 32'h0);
        rst_nb = 1'b1;
        step();
        ifb.imemAck = 1'b1; ifb.imemData = 32'h4444_4444;
        step();
        ifb.imemAck = 1'b0;
        chk("wrap_instr", ifb.instr, 32'h4444_4444);
        step();
        chk("wrap_addr1", ifb.imemAddr, 32'h0);
        chk("wrap_req1", 32'(ifb.imemReq), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_fetch_32.md
Name: pc_fetch_32

Overview:
- 32-bit program-counter and instruction-fetch stage; owns the architectural PC and handshakes with instruction memory.
- Drives pcPlus4 into the next-PC twoToOneMux_32 (inA, sequential path).
- Consumes the resolved next-PC target from that mux's output (branch/jump path) as redirectPc.
- Delivers one instruction at a time to decode with a valid/stall handshake.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment for sequential fetch

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
redirectValid  input  1  one-cycle request to load redirectPc (taken branch/jump)
redirectPc  input  32  redirect target (from next-PC mux out)
stall  input  1  decode cannot accept; hold delivered instruction
imemReq  output  1  fetch request to instruction memory
imemAddr  output  32  fetch address, equals pc
imemAck  input  1  memory returns imemData this cycle
imemData  input  32  fetched instruction word
instr  output  32  instruction presented to decode
instrValid  output  1  instr is valid
pc  output  32  address of current fetch or delivered instruction
pcPlus4  output  32  pc + PC_STEP, combinational, mod 2^32

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n. Sampled only at the rising edge.
- Reset values: pc=RESET_PC, instr=0, instrValid=0, imemReq=0, squash=0, pendingPc=0, state=BOOT. imemAddr=pc=RESET_PC.
- Reset mid-transaction: an outstanding request is abandoned. A late imemAck arriving in BOOT is ignored.
- Arithmetic: pcPlus4 and the pc increment are 32-bit modulo, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.

FSM: BOOT, FETCH, DELIVER.
- BOOT:
  - No request.
  - Next cycle -> FETCH.
  - A redirect seen in BOOT loads pc directly.
- FETCH:
  - imemReq=1, imemAddr=pc, held stable until imemAck.
  - imemAck with squash=0 and redirectValid=0: instr<=imemData, instrValid<=1, -> DELIVER. Fetch latency is 1 cycle after ack.
  - imemAck with squash=1: discard data, pc<=pendingPc, squash<=0, stay FETCH. New request goes out next cycle.
  - imemAck with redirectValid=1 in the same cycle: discard data, pc<=redirectPc, stay FETCH.
  - redirectValid without ack: squash<=1, pendingPc<=redirectPc. pc and imemAddr are unchanged until ack.
  - A later redirect while squash is set overwrites pendingPc (latest wins).
- DELIVER:
  - imemReq=0, instrValid=1.
  - Priority: redirect > stall > advance.
  - redirectValid: instrValid<=0, pc<=redirectPc, -> FETCH. Ignores stall.
  - stall (no redirect): hold pc, instr and instrValid unchanged.
  - Otherwise: pc<=pc+PC_STEP, instrValid<=0, -> FETCH.
- Throughput: best case one instruction every 2 cycles with zero-wait memory.
- imemAck outside FETCH is ignored.

Optional Feature:
Macro: PC_MISALIGN_TRAP_EN
- Defined:
  - Adds output port misalignErr (1 bit, reset 0).
  - A redirect with redirectPc[1:0]!=2'b00 is ignored: no pc change, no squash.
  - misalignErr pulses high for exactly one cycle, the cycle after the redirect.
- Undefined:
  - No misalignErr port.
  - redirectPc[1:0] is forced to 2'b00 on load.

Test Plan:
- Reset and sequential fetch: rst_n=0 for 2 cycles then 1, zero-wait ack returning 32'hA000_0001, 32'hA000_0002 -> imemAddr 0x0 then 0x4; instr matches each word; instrValid pulses in DELIVER; pcPlus4=0x4 then 0x8.
- Stall hold: in DELIVER hold stall=1 for 3 cycles -> instr, pc and instrValid unchanged. After release, next imemAddr=pc+4.
- Redirect during wait: redirectPc=0x100 pulsed while imemAck is withheld 3 cycles at 0x8 -> data at 0x8 discarded, instrValid stays 0, next imemAddr=0x100.
- Redirect vs stall in DELIVER: stall=1 and redirectValid=1 with redirectPc=0x40 -> instrValid falls, next imemAddr=0x40.
- Wrap and reset mid-op: RESET_PC=32'hFFFF_FFFC -> pcPlus4=0, second fetch address 0x0. Assert rst_n=0 during an outstanding request -> all outputs at reset values next cycle; a late ack is ignored.
- Misalign, checked in both builds: redirectPc=0x102.
  - PC_MISALIGN_TRAP_EN defined: pc unchanged, misalignErr high for one cycle.
  - PC_MISALIGN_TRAP_EN undefined: pc=0x100.
